// File: rtl/serial_rx_deserializer.sv
// Serial-line receiver: start/data/(parity)/stop framing into a valid/ready word stream.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit after the data bits.
module serial_rx_deserializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state, state_nx;
  logic             rx_meta, rx_s, rx_prev;
  logic [CW-1:0]    cnt, cnt_val;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             tick, cnt_load, shift_en, bit_clr;
  logic             word_done, frame_bad, stop_sample;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_capture, par_bad;
`endif

  assign tick = (cnt == '0);

  // Control decode: every sampling action happens on a tick of the sample counter.
  always_comb begin
    state_nx    = state;
    cnt_load    = 1'b0;
    cnt_val     = FULL_LOAD;
    shift_en    = 1'b0;
    bit_clr     = 1'b0;
    word_done   = 1'b0;
    frame_bad   = 1'b0;
    stop_sample = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_capture = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nx = S_START;
          cnt_load = 1'b1;
          cnt_val  = HALF_LOAD;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DATA;
            cnt_load = 1'b1;
            bit_clr  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_capture = 1'b1;
          cnt_load    = 1'b1;
          state_nx    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          stop_sample = 1'b1;
          if (rx_s) begin
            word_done = 1'b1;
            state_nx  = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nx  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output handshake: a word is offered while data_valid=1 and is consumed on
  // any edge where data_valid && data_ready; data_out is stable until then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      state   <= state_nx;

      if (cnt_load)      cnt <= cnt_val;
      else if (!tick)    cnt <= cnt - CW'(1);

      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BW'(1);

      if (shift_en) shift <= {rx_s, shift[WIDTH-1:1]};

`ifdef SERIAL_RX_PARITY_EN
      if (par_capture) par_bad <= (^shift) ^ rx_s;
      parity_err <= stop_sample && par_bad;
`else
      parity_err <= 1'b0;
`endif

      frame_err <= frame_bad;
      overrun   <= word_done && data_valid && !data_ready;

      // A completing word may replace one being consumed in the same cycle.
      if (word_done && (!data_valid || data_ready)) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_rx_deserializer.md
# serial_rx_deserializer

Receive end of the single-wire serial output link driven by the chip's `serializer` block, used on the board-side test FPGA and in the on-chip loopback path. It reconstructs WIDTH-bit words from an asynchronous-to-data, same-clock-domain serial line and presents them on a valid/ready interface. It also flags framing, overrun and (optionally) parity errors.

## Interface
- `WIDTH`, 8: data bits per frame.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; legal range 4..1023.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `serial_in`  in  1  serial line; idles high.
- `data_out`  out  WIDTH  received word; stable while `data_valid`=1.
- `data_valid`  out  1  word available.
- `data_ready`  in  1  consumer accepts; transfer when `data_valid`&&`data_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: new word completed while previous still held.
- `parity_err`  out  1  one-cycle pulse (tied 0 when parity is compiled out).

## Operation
- Frame format: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1).
- `serial_in` passes through a 2-flop synchronizer (`rx_s`) before any use; the synchronizer resets to 1.
- Bit counter `bit_cnt` is ceil(log2(WIDTH+1)) bits wide; sample counter is ceil(log2(CLKS_PER_BIT)) bits wide.
- State machine:
  - IDLE: on `rx_s` 1→0, load sample counter with CLKS_PER_BIT/2−1 (integer division) and go to START.
  - START: at counter 0, sample. If 1 (false start), go to IDLE. If 0, reload CLKS_PER_BIT−1, clear `bit_cnt`, go to DATA.
  - DATA: at each counter 0, shift the sample into the MSB of the shift register, shifting right, and reload. After WIDTH samples go to PARITY if compiled in, else STOP.
  - PARITY: one sample; compare against even parity of the data bits; go to STOP.
  - STOP: sample 1 → word complete, go to IDLE. Sample 0 → pulse `frame_err`, discard word, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- Word complete:
  - If `data_valid`=0, or `data_ready`=1 in the same cycle, load `data_out` and set `data_valid`.
  - Otherwise pulse `overrun`; the held word is kept and the new word is dropped.
- `data_valid` clears the cycle after the transfer unless a new word loads in that same cycle.
- A parity mismatch pulses `parity_err`; the word is still delivered.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0, state=IDLE, counters=0.
- `rst_n` low mid-frame aborts the frame on the next edge; no error pulse is generated.
- Detection latency: 2 cycles (synchronizer) plus 1 (edge detect) after the line falls.
- Start sample occurs CLKS_PER_BIT/2 cycles after edge detect. Each later sample occurs CLKS_PER_BIT cycles after the previous one.
- `data_valid` rises 1 cycle after the stop-bit sample; `frame_err`, `overrun` and `parity_err` pulse in that same cycle.
- `data_ready` may be held high permanently; back-to-back frames with no idle gap are received without loss.
- The next start edge is accepted from the first cycle in IDLE. Tolerated rate mismatch is about ±4% per frame.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - PARITY state present; frame length is WIDTH+3 bits.
  - `parity_err` is live, with even parity: data bits XOR parity bit = 0.
- Not defined:
  - Frame length is WIDTH+2 bits; no PARITY state.
  - `parity_err` is constant 0.
  - A transmitter that sends parity will cause framing errors.

## Test plan
- Reset with `serial_in`=1, then send 0xA5 with `data_ready`=1 → `data_valid` high 1 cycle with `data_out`=0xA5, no error pulses.
- 10 µs-equivalent glitch: `serial_in` low for 5 cycles, then high → returns to IDLE, no `data_valid`, no `frame_err`.
- Send 0x3C with the stop bit forced 0, line held low 40 cycles, then 0x81 → `frame_err` pulse once, no word for 0x3C, then `data_out`=0x81.
- `data_ready`=0, send 0x11 then 0x22 → `data_valid` high with 0x11, `overrun` pulses at the end of 0x22. Raise `data_ready` → 0x11 consumed, `data_valid` drops, 0x22 never appears.
- With `SERIAL_RX_PARITY_EN`: send 0x07 with a wrong parity bit → `parity_err` pulse, `data_out`=0x07 delivered. Send 0x07 with correct parity → no pulse.
- Assert `rst_n`=0 for 1 cycle mid-way through data bit 4 of 0xFF, then send 0x5A → no word for 0xFF, `data_out`=0x5A, no error pulses.
